// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//   Store-path aligner between the execute/memory stage and the data-memory
//   write port. Accepts a store request (byte address, size, right-justified
//   register data) and emits NBYTES-aligned, byte-masked bus beats. Lanes not
//   written are driven to zero. Both handshakes are valid/ready with the bus
//   side fully registered.
//
//   Optional feature macro: SPLIT_MISALIGNED_EN
//     defined   : misaligned stores are performed; a store crossing an NBYTES
//                 word boundary is issued as two beats (beat0, then beat1).
//                 err flags only an illegal size.
//     undefined : every misaligned store is rejected with err (address error);
//                 no FIRST state and no beat1 storage exist.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_addr  [ADDR_W]    byte address
//   req_size  [2]         0=byte 1=half 2=word 3=dword (dword needs DATA_W=64)
//   req_data  [DATA_W]    store data, right-justified
//   bus_valid/bus_ready   beat handshake
//   bus_addr  [ADDR_W]    NBYTES-aligned beat address
//   bus_mask  [NBYTES]    byte write enables, bit i = lane i
//   bus_data  [DATA_W]    lane-aligned data, unmasked lanes zero
//   err                   one-cycle pulse: request consumed and rejected
//   busy                  state is not IDLE
// -----------------------------------------------------------------------------
module store_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_mask,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  err,
  output logic                  busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFS_W  = $clog2(NBYTES);

`ifdef SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_LAST} state_e;
`else
  typedef enum logic [0:0] {S_IDLE, S_LAST} state_e;
`endif

  state_e              state_q, state_d;
  logic                bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [NBYTES-1:0]   bus_mask_q, bus_mask_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic                err_q, err_d;
`ifdef SPLIT_MISALIGNED_EN
  logic [NBYTES-1:0]   b1_mask_q, b1_mask_d;
  logic [DATA_W-1:0]   b1_data_q, b1_data_d;
  logic [NBYTES-1:0]   m_hi;
  logic [DATA_W-1:0]   d_hi;
  logic                split;
`else
  logic                misaligned;
`endif

  logic [OFS_W-1:0]    ofs;
  int                  nb;
  logic [NBYTES-1:0]   byte_en;
  logic [DATA_W-1:0]   data_sel;
  logic                illegal;
  logic                req_err;
  logic [ADDR_W-1:0]   addr_al;
  logic [NBYTES-1:0]   m_lo;
  logic [DATA_W-1:0]   d_lo;
  logic                accept;
  logic                load;

  // Request decode: lane enables and data for the incoming store.
  always_comb begin
    ofs      = req_addr[OFS_W-1:0];
    nb       = 1 << req_size;
    byte_en  = '0;
    data_sel = '0;
    for (int i = 0; i < NBYTES; i++) begin
      byte_en[i]         = (i < nb);
      data_sel[8*i +: 8] = byte_en[i] ? req_data[8*i +: 8] : 8'h00;
    end
    illegal = (nb > NBYTES);
    addr_al = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
`ifdef SPLIT_MISALIGNED_EN
    // Double-width shift: the upper half is whatever spills into the next word.
    {m_hi, m_lo} = {{NBYTES{1'b0}}, byte_en} << ofs;
    {d_hi, d_lo} = {{DATA_W{1'b0}}, data_sel} << {ofs, 3'b000};
    split        = (int'(ofs) + nb) > NBYTES;
    req_err      = illegal;
`else
    // Aligned legal stores never cross a word, so a single-width shift suffices.
    m_lo       = byte_en << ofs;
    d_lo       = data_sel << {ofs, 3'b000};
    misaligned = (int'(ofs) & (nb - 1)) != 0;
    req_err    = illegal || misaligned;
`endif
  end

  // A new request may enter while the last beat leaves in the same cycle.
  assign req_ready = rst_n && ((state_q == S_IDLE) || ((state_q == S_LAST) && bus_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_mask_d  = bus_mask_q;
    bus_data_d  = bus_data_q;
    err_d       = 1'b0;
`ifdef SPLIT_MISALIGNED_EN
    b1_mask_d   = b1_mask_q;
    b1_data_d   = b1_data_q;
`endif
    load        = 1'b0;

    case (state_q)
      S_IDLE: load = accept;
`ifdef SPLIT_MISALIGNED_EN
      S_FIRST: begin
        if (bus_ready) begin
          state_d    = S_LAST;
          bus_addr_d = bus_addr_q + ADDR_W'(NBYTES);
          bus_mask_d = b1_mask_q;
          bus_data_d = b1_data_q;
        end
      end
`endif
      S_LAST: begin
        if (bus_ready) begin
          state_d     = S_IDLE;
          bus_valid_d = 1'b0;
          load        = accept;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      if (req_err) begin
        // Rejected request is consumed without producing a beat.
        err_d       = 1'b1;
        state_d     = S_IDLE;
        bus_valid_d = 1'b0;
      end else begin
        state_d     = S_LAST;
        bus_valid_d = 1'b1;
        bus_addr_d  = addr_al;
        bus_mask_d  = m_lo;
        bus_data_d  = d_lo;
`ifdef SPLIT_MISALIGNED_EN
        b1_mask_d   = m_hi;
        b1_data_d   = d_hi;
        if (split) state_d = S_FIRST;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_mask_q  <= '0;
      bus_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef SPLIT_MISALIGNED_EN
      b1_mask_q   <= '0;
      b1_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_mask_q  <= bus_mask_d;
      bus_data_q  <= bus_data_d;
      err_q       <= err_d;
`ifdef SPLIT_MISALIGNED_EN
      b1_mask_q   <= b1_mask_d;
      b1_data_q   <= b1_data_d;
`endif
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_mask  = bus_mask_q;
  assign bus_data  = bus_data_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, bus_valid, bus_ready, err, busy;
  logic [31:0] req_addr, req_data, bus_addr, bus_data;
  logic [1:0]  req_size;
  logic [3:0]  bus_mask;

  logic        req_valid64, req_ready64, bus_valid64, err64, busy64;
  logic [31:0] req_addr64, bus_addr64;
  logic [1:0]  req_size64;
  logic [63:0] req_data64, bus_data64;
  logic [7:0]  bus_mask64;
  logic        bus_ready64;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;
  beat_t sb[$];

  store_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_data(req_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_mask(bus_mask), .bus_data(bus_data), .err(err), .busy(busy)
  );

  store_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64),
    .req_size(req_size64), .req_data(req_data64),
    .bus_valid(bus_valid64), .bus_ready(bus_ready64), .bus_addr(bus_addr64),
    .bus_mask(bus_mask64), .bus_data(bus_data64), .err(err64), .busy(busy64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every completed beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus_valid && bus_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {32'h0, bus_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_addr", bus_addr, e.addr);
        chk("beat_mask", bus_mask, e.mask);
        chk("beat_data", bus_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.mask = m; b.data = d;
    sb.push_back(b);
  endtask

  // Holds the request until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_size = s; req_data = d;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d,
                        input logic [31:0] ea, input logic [7:0] em, input logic [63:0] ed);
    req_valid64 = 1'b1; req_addr64 = a; req_size64 = s; req_data64 = d;
    @(negedge clk);
    chk("w64_req_ready", req_ready64, 1);
    step();
    req_valid64 = 1'b0;
    @(negedge clk);
    chk("w64_valid", bus_valid64, 1);
    chk("w64_addr", bus_addr64, ea);
    chk("w64_mask", bus_mask64, em);
    chk("w64_data", bus_data64, ed);
    chk("w64_err", err64, 0);
    step();
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; bus_ready = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_data = '0;
    req_valid64 = 1'b0; req_addr64 = '0; req_size64 = '0; req_data64 = '0;
    bus_ready64 = 1'b1;

    // Reset state
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_mask", bus_mask, 0);
    chk("rst_bus_data", bus_data, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    step();

    // sw aligned
    bus_ready = 1'b1;
    push(32'h100, 4'b1111, 32'hDEADBEEF);
    send(32'h100, 2'd2, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_valid", bus_valid, 1);
    chk("sw_err", err, 0);
    step();
    @(negedge clk);
    chk("sw_drained", bus_valid, 0);
    chk("sw_idle", busy, 0);
    step();

    // sb to top lane
    push(32'h200, 4'b1000, 32'hA5000000);
    send(32'h203, 2'd0, 32'h123456A5);
    step();

    // sh with back-pressure: beat held stable, request side blocked
    bus_ready = 1'b0;
    push(32'h100, 4'b1100, 32'h12340000);
    send(32'h102, 2'd1, 32'hFFFF1234);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", bus_valid, 1);
      chk("hold_addr", bus_addr, 32'h100);
      chk("hold_mask", bus_mask, 4'b1100);
      chk("hold_data", bus_data, 32'h12340000);
      chk("hold_req_ready", req_ready, 0);
      step();
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("hs_req_ready", req_ready, 1);
    step();
    @(negedge clk);
    chk("hold_drained", bus_valid, 0);
    step();

    // Back-to-back aligned stores, one accepted per cycle
    c0 = cyc;
    push(32'h400, 4'b0001, 32'h00000077);
    send(32'h400, 2'd0, 32'hFFFFFF77);
    push(32'h404, 4'b1100, 32'hBBBB0000);
    send(32'h406, 2'd1, 32'hAAAABBBB);
    push(32'h408, 4'b1111, 32'hCAFEF00D);
    send(32'h408, 2'd2, 32'hCAFEF00D);
    chk("throughput_cycles", cyc - c0, 3);
    step();
    @(negedge clk);
    chk("b2b_drained", bus_valid, 0);
    chk("b2b_sb_empty", sb.size(), 0);
    step();

    // Misaligned stores
`ifdef SPLIT_MISALIGNED_EN
    push(32'h100, 4'b0110, 32'h00556600);
    send(32'h101, 2'd1, 32'h00005566);
    @(negedge clk);
    chk("mis_half_err", err, 0);
    step();
    push(32'h100, 4'b1000, 32'h44000000);
    push(32'h104, 4'b0111, 32'h00112233);
    send(32'h103, 2'd2, 32'h11223344);
    @(negedge clk);
    chk("split_err", err, 0);
    chk("split_busy", busy, 1);
    step();
    @(negedge clk);
    chk("split_beat1_valid", bus_valid, 1);
    step();
    @(negedge clk);
    chk("split_drained", bus_valid, 0);
    chk("split_sb_empty", sb.size(), 0);
    step();
`else
    send(32'h101, 2'd1, 32'h00005566);
    @(negedge clk);
    chk("mis_half_err", err, 1);
    chk("mis_half_valid", bus_valid, 0);
    step();
    send(32'h103, 2'd2, 32'h11223344);
    @(negedge clk);
    chk("mis_word_err", err, 1);
    chk("mis_word_valid", bus_valid, 0);
    step();
    @(negedge clk);
    chk("mis_err_pulse", err, 0);
    chk("mis_word_idle", bus_valid, 0);
    step();
`endif

    // Illegal size on 32-bit bus
    send(32'h500, 2'd3, 32'h01020304);
    @(negedge clk);
    chk("sd32_err", err, 1);
    chk("sd32_valid", bus_valid, 0);
    chk("sd32_busy", busy, 0);
    step();
    @(negedge clk);
    chk("sd32_err_pulse", err, 0);
    step();

    // Erroring request accepted in LAST as the pending beat completes
    bus_ready = 1'b0;
    push(32'h300, 4'b1111, 32'h0BADF00D);
    send(32'h300, 2'd2, 32'h0BADF00D);
    bus_ready = 1'b1;
    send(32'h304, 2'd3, 32'h55555555);
    @(negedge clk);
    chk("last_err", err, 1);
    chk("last_err_valid", bus_valid, 0);
    chk("last_err_busy", busy, 0);
    chk("last_err_sb_empty", sb.size(), 0);
    step();

    // Reset while a beat is pending
    bus_ready = 1'b0;
    send(32'h600, 2'd2, 32'h13572468);
    @(negedge clk);
    chk("pend_valid", bus_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    bus_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("postrst_valid", bus_valid, 0);
    chk("postrst_req_ready", req_ready, 1);
    step();

`ifdef SPLIT_MISALIGNED_EN
    // Reset in FIRST discards the pending beat1
    bus_ready = 1'b0;
    send(32'h103, 2'd2, 32'h11223344);
    @(negedge clk);
    chk("first_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("first_rst_valid", bus_valid, 0);
    step();
    rst_n = 1'b1;
    bus_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("first_rst_idle", busy, 0);
    chk("first_rst_req_ready", req_ready, 1);
    chk("first_rst_no_beat1", bus_valid, 0);
    step();
`endif

    // 64-bit bus
    send64(32'h8, 2'd3, 64'h0123456789ABCDEF, 32'h8, 8'hFF, 64'h0123456789ABCDEF);
    send64(32'hC, 2'd2, 64'h89ABCDEF12345678, 32'h8, 8'hF0, 64'h1234567800000000);
    send64(32'h1E, 2'd1, 64'h000000000000BEEF, 32'h18, 8'hC0, 64'hBEEF000000000000);

    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
